// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// the FSM state encoding and the pattern-length legality check.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_HUNT = 2'd1;
  localparam logic [1:0] STATE_HIT  = 2'd2;

  // A length is usable only if it selects at least one bit and fits the history.
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 32'd1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_pattern_det.sv
// Run-time programmable serial pattern detector: compares the last len accepted
// bits against a loaded pattern, flags matches as a Moore output and counts them.
module seq_pattern_det
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               err_q, err_d;

  logic               load_legal;
  logic               accept;
  logic               match;
  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic               count_clr;
  logic               count_inc;

  assign load_legal = len_legal(32'(cfg_len), MAX_LEN);
  // A load in the same cycle drops the sample; IDLE never looks at the stream.
  assign accept     = din_valid && !cfg_load && (state_q != ST_IDLE);
  assign hist_shift = {hist_q[MAX_LEN-2:0], din};

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign match = accept
              && (({1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_q})
              && (((hist_shift ^ pat_q) & len_mask) == '0);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    err_d   = err_q;

    if (cfg_load) begin
      err_d  = !load_legal;
      hist_d = '0;
      fill_d = '0;
      if (load_legal) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        state_d = ST_HUNT;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_HUNT, ST_HIT: state_d = match ? ST_HIT : ST_HUNT;
        default:         state_d = ST_IDLE;
      endcase

      if (accept) begin
        hist_d = hist_shift;
        // Non-overlapping mode restarts the fill so the next hit needs len new bits.
        if (match && !ovl_q) begin
          fill_d = '0;
        end else if (fill_q != LEN_W'(MAX_LEN)) begin
          fill_d = fill_q + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      err_q   <= err_d;
    end
  end

  assign count_clr = cfg_load;
  assign count_inc = (state_d == ST_HIT);

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (count_clr),
    .inc  (count_inc),
    .count(match_count)
  );

  assign dout    = (state_q == ST_HIT);
  assign armed   = (state_q != ST_IDLE);
  assign cfg_err = err_q;

endmodule
